// File: rtl/alu_result_fifo.sv
// Register FIFO that captures ALU results and flags for the write-back consumer.
// It also keeps a sticky overflow flag and a saturating overflow-event counter.
module alu_result_fifo #(
  parameter int DEPTH = 4,
  parameter int CNTW  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              res,
  input  logic                     Co,
  input  logic                     zero,
  input  logic                     overflow,
  input  logic [2:0]               ALU_Ctr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_res,
  output logic [2:0]               out_flags,
  output logic [2:0]               out_ctr,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf_sticky,
  output logic [CNTW-1:0]          ovf_cnt,
  input  logic                     clr_sticky
);

  localparam int AW      = $clog2(DEPTH);
  localparam int ENTRY_W = 3 + 3 + 32;
  localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]      r_wp;
  logic [AW-1:0]      r_rp;
  logic [AW:0]        r_count;
  logic               r_ovf_sticky;
  logic [CNTW-1:0]    r_ovf_cnt;

  logic               w_push;
  logic               w_pop;
  logic               w_ovf_push;
  logic [ENTRY_W-1:0] w_head;
  logic [ENTRY_W-1:0] w_entry;

  // Readiness depends only on registered occupancy, so a pop never frees a slot early.
  assign in_ready   = (r_count != C_FULL);
  assign out_valid  = (r_count != '0);
  assign w_push     = in_valid & in_ready;
  assign w_pop      = out_valid & out_ready;
  assign w_ovf_push = w_push & overflow;

  assign w_entry = {ALU_Ctr, overflow, Co, zero, res};

  always_ff @(posedge clk) begin
    if (rst && w_push) begin
      r_mem[r_wp] <= w_entry;
    end
  end

  assign w_head    = r_mem[r_rp];
  assign out_res   = w_head[31:0];
  assign out_flags = w_head[34:32];
  assign out_ctr   = w_head[37:35];

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wp <= r_wp + 1'b1;
      end
      if (w_pop) begin
        r_rp <= r_rp + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // A qualifying push in the same cycle as a clear wins and restarts the count at one.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ovf_sticky <= 1'b0;
      r_ovf_cnt    <= '0;
    end else if (w_ovf_push) begin
      r_ovf_sticky <= 1'b1;
      if (clr_sticky) begin
        r_ovf_cnt <= CNTW'(1);
      end else if (r_ovf_cnt != '1) begin
        r_ovf_cnt <= r_ovf_cnt + 1'b1;
      end
    end else if (clr_sticky) begin
      r_ovf_sticky <= 1'b0;
      r_ovf_cnt    <= '0;
    end
  end

  assign count      = r_count;
  assign ovf_sticky = r_ovf_sticky;
  assign ovf_cnt    = r_ovf_cnt;

endmodule

// File: tb/tb_alu_result_fifo.sv
// Randomised and directed bench for alu_result_fifo against a queue-based model.
module tb_alu_result_fifo;
  localparam int DEPTH = 4;
  localparam int CNTW  = 8;
  localparam int CMAX  = (1 << CNTW) - 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] res;
  logic        Co;
  logic        zero;
  logic        overflow;
  logic [2:0]  ALU_Ctr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_res;
  logic [2:0]  out_flags;
  logic [2:0]  out_ctr;
  logic [2:0]  count;
  logic        ovf_sticky;
  logic [7:0]  ovf_cnt;
  logic        clr_sticky;

  alu_result_fifo #(.DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .res(res), .Co(Co), .zero(zero), .overflow(overflow), .ALU_Ctr(ALU_Ctr),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
    .out_flags(out_flags), .out_ctr(out_ctr), .count(count),
    .ovf_sticky(ovf_sticky), .ovf_cnt(ovf_cnt), .clr_sticky(clr_sticky)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit check_en = 1'b0;

  typedef struct {
    logic [31:0] r;
    logic [2:0]  fl;
    logic [2:0]  ct;
  } entry_t;

  entry_t m_q[$];
  bit     m_sticky = 1'b0;
  int     m_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: occupancy is decided from the queue size before this edge.
  always @(posedge clk) begin
    if (!rst) begin
      m_q.delete();
      m_sticky = 1'b0;
      m_cnt = 0;
    end else begin
      bit push, pop;
      entry_t e;
      push = in_valid && (m_q.size() < DEPTH);
      pop  = out_ready && (m_q.size() > 0);
      if (pop) void'(m_q.pop_front());
      if (push) begin
        e.r = res; e.fl = {overflow, Co, zero}; e.ct = ALU_Ctr;
        m_q.push_back(e);
      end
      if (push && overflow) begin
        m_sticky = 1'b1;
        m_cnt = clr_sticky ? 1 : ((m_cnt < CMAX) ? m_cnt + 1 : CMAX);
      end else if (clr_sticky) begin
        m_sticky = 1'b0;
        m_cnt = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("count", 64'(count), 64'(m_q.size()));
      chk("out_valid", 64'(out_valid), 64'(m_q.size() != 0));
      chk("in_ready", 64'(in_ready), 64'(m_q.size() != DEPTH));
      chk("ovf_sticky", 64'(ovf_sticky), 64'(m_sticky));
      chk("ovf_cnt", 64'(ovf_cnt), 64'(m_cnt));
      if (m_q.size() != 0) begin
        chk("out_res", 64'(out_res), 64'(m_q[0].r));
        chk("out_flags", 64'(out_flags), 64'(m_q[0].fl));
        chk("out_ctr", 64'(out_ctr), 64'(m_q[0].ct));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] r, input logic [2:0] c,
                       input logic ov, input logic co, input logic z);
    in_valid = v; res = r; ALU_Ctr = c; overflow = ov; Co = co; zero = z;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) step();
    out_ready = 1'b0;
  endtask

  logic [31:0] exp_vals [4];

  initial begin
    rst = 1'b0; in_valid = 1'b0; res = '0; Co = 1'b0; zero = 1'b0; overflow = 1'b0;
    ALU_Ctr = '0; out_ready = 1'b0; clr_sticky = 1'b0;
    step();
    step();
    check_en = 1'b1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_sticky", 64'(ovf_sticky), 64'd0);
    chk("rst_cnt", 64'(ovf_cnt), 64'd0);
    rst = 1'b1;

    drive(1'b1, 32'h5, 3'b010, 1'b0, 1'b0, 1'b0);
    step();
    in_valid = 1'b0;
    chk("single_valid", 64'(out_valid), 64'd1);
    chk("single_res", 64'(out_res), 64'h5);
    chk("single_ctr", 64'(out_ctr), 64'd2);
    chk("single_count", 64'(count), 64'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("single_pop_count", 64'(count), 64'd0);

    exp_vals[0] = 32'h11; exp_vals[1] = 32'h22; exp_vals[2] = 32'h33; exp_vals[3] = 32'h44;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, exp_vals[i], 3'(i), 1'b0, 1'b0, 1'b0);
      step();
    end
    chk("full_count", 64'(count), 64'd4);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    drive(1'b1, 32'h55, 3'd5, 1'b0, 1'b0, 1'b0);
    step();
    in_valid = 1'b0;
    chk("drop_count", 64'(count), 64'd4);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_order", 64'(out_res), 64'(exp_vals[i]));
      step();
    end
    out_ready = 1'b0;
    chk("drain_empty", 64'(out_valid), 64'd0);

    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'hA0 + 32'(i), 3'(i), 1'b0, 1'b0, 1'b1);
      step();
    end
    drive(1'b1, 32'hB0, 3'd7, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b1;
    step();
    chk("full_pop_only", 64'(count), 64'd3);
    step();
    in_valid = 1'b0;
    chk("full_then_push", 64'(count), 64'd3);
    chk("full_then_head", 64'(out_res), 64'hA2);
    drain();

    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'hC0 + 32'(i), 3'd1, 1'b0, 1'b0, 1'b0);
      step();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'hD0 + 32'(i), 3'd4, 1'b0, 1'b1, 1'b0);
      step();
      chk("stream_count", 64'(count), 64'd2);
    end
    chk("stream_head", 64'(out_res), 64'hD8);
    drain();

    drive(1'b1, 32'h8000_0000, 3'd2, 1'b1, 1'b1, 1'b0);
    step();
    in_valid = 1'b0;
    chk("ovf_flags", 64'(out_flags), 64'b110);
    chk("ovf_sticky_set", 64'(ovf_sticky), 64'd1);
    chk("ovf_cnt_one", 64'(ovf_cnt), 64'd1);
    drive(1'b1, 32'h7FFF_FFFF, 3'd2, 1'b1, 1'b0, 1'b0);
    clr_sticky = 1'b1;
    step();
    in_valid = 1'b0;
    chk("set_wins_sticky", 64'(ovf_sticky), 64'd1);
    chk("set_wins_cnt", 64'(ovf_cnt), 64'd1);
    step();
    clr_sticky = 1'b0;
    chk("clr_sticky", 64'(ovf_sticky), 64'd0);
    chk("clr_cnt", 64'(ovf_cnt), 64'd0);
    drain();

    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'hE0 + 32'(i), 3'd3, 1'b1, 1'b0, 1'b0);
      step();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'hF0 + 32'(i), 3'd3, 1'b1, 1'b0, 1'b0);
      step();
    end
    out_ready = 1'b0;
    chk("pre_rst_count", 64'(count), 64'd3);
    chk("pre_rst_cnt", 64'(ovf_cnt), 64'd5);
    rst = 1'b0;
    step();
    rst = 1'b1;
    in_valid = 1'b0;
    chk("mid_rst_count", 64'(count), 64'd0);
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_sticky", 64'(ovf_sticky), 64'd0);
    chk("mid_rst_cnt", 64'(ovf_cnt), 64'd0);

    out_ready = 1'b1;
    for (int i = 0; i < CMAX + 5; i++) begin
      drive(1'b1, 32'(i), 3'd6, 1'b1, 1'b0, 1'b0);
      step();
    end
    in_valid = 1'b0;
    chk("cnt_saturate", 64'(ovf_cnt), 64'(CMAX));
    drain();

    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom(), 3'($urandom_range(0, 7)),
            $urandom_range(0, 3) == 0, 1'($urandom), 1'($urandom));
      out_ready  = $urandom_range(0, 2) != 0;
      clr_sticky = $urandom_range(0, 15) == 0;
      rst        = $urandom_range(0, 199) != 0;
      step();
    end
    rst = 1'b1; in_valid = 1'b0; clr_sticky = 1'b0;
    drain();
    check_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
